// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - burst read controller for a synchronous FIFO with a 2-entry output buffer
module fifo_burst_reader #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 16,
  parameter int LEN_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 abort_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rd_en_o,
  input  logic [WIDTH-1:0]     fifo_rdata_i,
  output logic                 m_valid_o,
  output logic [WIDTH-1:0]     m_data_o,
  input  logic                 m_ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [LEN_WIDTH-1:0] rd_count_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [LEN_WIDTH-1:0] rd_count_q, rd_count_d;
  logic                 inflight_q, inflight_d;
  logic [1:0]           buf_cnt_q, buf_cnt_d;
  logic [WIDTH-1:0]     buf0_q, buf0_d;
  logic [WIDTH-1:0]     buf1_q, buf1_d;

  logic                 hs;
  logic                 pop;
  logic [1:0]           occupancy;

  // Pop decision: only pop when the word it returns is guaranteed a buffer slot
  always_comb begin
    hs        = (buf_cnt_q != 2'd0) & m_ready_i;
    // Slots that will be taken once the in-flight word lands and this cycle's
    // handshake retires the head; hs implies buf_cnt_q >= 1, so no underflow.
    occupancy = buf_cnt_q + {1'b0, inflight_q} - {1'b0, hs};
    pop       = (state_q == S_RUN) && (remaining_q != '0) && !fifo_empty_i &&
                !abort_i && !rst_i && (occupancy < 2'd2);
  end

  // Buffer datapath: head in buf0, tail in buf1; unload before load keeps order
  always_comb begin
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    buf_cnt_d = buf_cnt_q;
    if (hs) begin
      if (buf_cnt_q == 2'd2) begin
        buf0_d = buf1_q;
      end
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    if (inflight_q) begin
      // buf0 keeps the last delivered word while empty, so m_data_o holds it.
      if (buf_cnt_d == 2'd0) begin
        buf0_d = fifo_rdata_i;
      end else begin
        buf1_d = fifo_rdata_i;
      end
      buf_cnt_d = buf_cnt_d + 2'd1;
    end
  end

  // Next-state logic plus counter and in-flight bookkeeping
  always_comb begin
    state_d     = state_q;
    inflight_d  = pop;
    remaining_d = remaining_q;
    rd_count_d  = rd_count_q + {{(LEN_WIDTH-1){1'b0}}, hs};
    if (pop) begin
      remaining_d = remaining_q - LEN_ONE;
    end
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rd_count_d = '0;
          if (len_i != '0) begin
            remaining_d = len_i;
            state_d     = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (abort_i) begin
          remaining_d = '0;
          state_d     = S_DRAIN;
        end else if (remaining_d == '0) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Look at next-cycle occupancy so done_o follows the last handshake directly.
        if (!inflight_d && (buf_cnt_d == 2'd0)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset dropping all held data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      rd_count_q  <= '0;
      inflight_q  <= 1'b0;
      buf_cnt_q   <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      rd_count_q  <= rd_count_d;
      inflight_q  <= inflight_d;
      buf_cnt_q   <= buf_cnt_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

  // Output mapping
  always_comb begin
    fifo_rd_en_o = pop;
    m_valid_o    = (buf_cnt_q != 2'd0);
    m_data_o     = buf0_q;
    busy_o       = (state_q != S_IDLE);
    done_o       = (state_q == S_DONE);
    rd_count_o   = rd_count_q;
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - directed table and sequence bench for fifo_burst_reader
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] len = 5'd0;
  logic       abort = 1'b0;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [3:0] fifo_rdata = 4'd0;
  logic       m_valid;
  logic [3:0] m_data;
  logic       m_ready = 1'b0;
  logic       busy;
  logic       done;
  logic [4:0] rd_count;

  fifo_burst_reader #(.WIDTH(4), .DEPTH(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .len_i        (len),
    .abort_i      (abort),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_en_o (fifo_rd_en),
    .fifo_rdata_i (fifo_rdata),
    .m_valid_o    (m_valid),
    .m_data_o     (m_data),
    .m_ready_i    (m_ready),
    .busy_o       (busy),
    .done_o       (done),
    .rd_count_o   (rd_count)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data, empty straight from the pointers
  logic [3:0] mem [0:63];
  int         wp = 0;
  int         rp = 0;
  logic       underflow_seen = 1'b0;

  assign fifo_empty = (wp == rp);

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (wp == rp) underflow_seen <= 1'b1;
      fifo_rdata <= mem[rp[5:0]];
      rp <= rp + 1;
    end
  end

  typedef struct {
    int st, ln, rdy, ab;
    int rd, v, d, dn, bsy, cnt;
  } vec_t;

  vec_t       vt[13];
  int         vectors = 0;
  int         errors = 0;
  int         pops = 0;
  int         dones = 0;
  logic       last_rd, last_v;
  logic [3:0] last_d;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_word(input int d);
    mem[wp[5:0]] = 4'(d);
    wp = wp + 1;
  endtask

  // Called at a negedge: drive, sample 1ns later, track handshakes, move to next negedge.
  task automatic step(input int st, input int ln, input int rdy, input int ab);
    logic [3:0] e;
    start   = (st != 0);
    len     = 5'(ln);
    m_ready = (rdy != 0);
    abort   = (ab != 0);
    #1;
    last_rd = fifo_rd_en;
    last_v  = m_valid;
    last_d  = m_data;
    if (fifo_rd_en) pops++;
    if (done) dones++;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL extra_word: got %0d, expected no word", m_data);
      end else begin
        e = exp_q.pop_front();
        check("word_order", m_data, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic run_to_done(input string name);
    int d0;
    d0 = dones;
    for (int i = 0; i < 60 && dones == d0; i++) step(0, 0, 1, 0);
    check(name, dones - d0, 1);
  endtask

  initial begin
    // test 1 (len 5, ready high) then test 4 (len 0 with a non-empty FIFO)
    vt[0]  = '{1, 5, 1, 0,  0, 0, 0, 0, 0, 0};
    vt[1]  = '{0, 0, 1, 0,  1, 0, 0, 0, 1, 0};
    vt[2]  = '{0, 0, 1, 0,  1, 0, 0, 0, 1, 0};
    vt[3]  = '{0, 0, 1, 0,  1, 1, 1, 0, 1, 0};
    vt[4]  = '{0, 0, 1, 0,  1, 1, 2, 0, 1, 1};
    vt[5]  = '{0, 0, 1, 0,  1, 1, 3, 0, 1, 2};
    vt[6]  = '{0, 0, 1, 0,  0, 1, 4, 0, 1, 3};
    vt[7]  = '{0, 0, 1, 0,  0, 1, 5, 0, 1, 4};
    vt[8]  = '{0, 0, 1, 0,  0, 0, 5, 1, 1, 5};
    vt[9]  = '{0, 0, 1, 0,  0, 0, 5, 0, 0, 5};
    vt[10] = '{1, 0, 1, 0,  0, 0, 5, 0, 0, 5};
    vt[11] = '{0, 0, 1, 0,  0, 0, 5, 1, 1, 0};
    vt[12] = '{0, 0, 1, 1,  0, 0, 5, 0, 0, 0};

    for (int i = 1; i <= 5; i++) push_word(i);
    for (int i = 6; i <= 13; i++) push_word(i);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      start   = (vt[i].st != 0);
      len     = 5'(vt[i].ln);
      m_ready = (vt[i].rdy != 0);
      abort   = (vt[i].ab != 0);
      #1;
      check($sformatf("row%0d_rd_en", i), fifo_rd_en, vt[i].rd);
      check($sformatf("row%0d_valid", i), m_valid, vt[i].v);
      check($sformatf("row%0d_data", i), m_data, vt[i].d);
      check($sformatf("row%0d_done", i), done, vt[i].dn);
      check($sformatf("row%0d_busy", i), busy, vt[i].bsy);
      check($sformatf("row%0d_count", i), rd_count, vt[i].cnt);
      @(negedge clk);
    end

    // test 2: 8 words, consumer stalls 4 cycles after the first word
    pops = 0; dones = 0;
    for (int i = 6; i <= 13; i++) exp_q.push_back(4'(i));
    step(1, 8, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      check("t2_stall_no_pop", last_rd, 0);
      check("t2_stall_valid", last_v, 1);
      check("t2_stall_data", last_d, 7);
    end
    run_to_done("t2_done");
    check("t2_count", rd_count, 8);
    check("t2_pops", pops, 8);
    check("t2_all_words", exp_q.size(), 0);

    // test 3: FIFO runs dry mid-burst, writer refills later
    pops = 0; dones = 0;
    push_word(14); push_word(15);
    exp_q.push_back(4'd14); exp_q.push_back(4'd15);
    exp_q.push_back(4'd9);  exp_q.push_back(4'd10);
    step(1, 4, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      check("t3_no_pop_empty", last_rd, 0);
    end
    check("t3_pops_before_refill", pops, 2);
    push_word(9); push_word(10);
    run_to_done("t3_done");
    check("t3_count", rd_count, 4);
    check("t3_all_words", exp_q.size(), 0);
    step(0, 0, 1, 0);
    check("t3_busy_after", busy, 0);
    check("t3_single_done", dones, 1);

    // test 5: abort on the third pop request
    pops = 0; dones = 0;
    for (int i = 1; i <= 6; i++) push_word(i);
    exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    step(1, 6, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    check("t5_abort_pop_suppressed", last_rd, 0);
    run_to_done("t5_done");
    check("t5_count", rd_count, 2);
    check("t5_pops", pops, 2);
    check("t5_fifo_retained", wp - rp, 4);
    check("t5_all_words", exp_q.size(), 0);

    // test 6: reset with one buffered and one in-flight word, then a fresh burst
    pops = 0; dones = 0;
    step(1, 4, 0, 0);
    step(0, 0, 0, 0);
    check("t6_pop1", last_rd, 1);
    step(0, 0, 0, 0);
    check("t6_pop2", last_rd, 1);
    rst = 1'b1;
    step(0, 0, 0, 0);
    check("t6_rst_rd_en", last_rd, 0);
    rst = 1'b0;
    step(0, 0, 0, 0);
    check("t6_valid", last_v, 0);
    check("t6_busy", busy, 0);
    check("t6_count", rd_count, 0);
    check("t6_rd_en", last_rd, 0);
    exp_q.push_back(4'd5); exp_q.push_back(4'd6);
    step(1, 2, 1, 0);
    run_to_done("t6_restart_done");
    check("t6_restart_count", rd_count, 2);
    check("t6_all_words", exp_q.size(), 0);

    check("no_underflow", underflow_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
